// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: ALU operation codes, opcode constants, the
// decoded instruction bundle carried from decode into execute, and the
// occupancy encoding of the ID/EX buffer.
package rv32i_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SRL  = 4'b0011,
        ALU_SRA  = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLLI = 4'b1001,
        ALU_SRLI = 4'b1010,
        ALU_SRAI = 4'b1011,
        ALU_SLTU = 4'b1100,
        ALU_PASS = 4'b1111
    } alu_ctrl_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Everything the ALU and writeback need for one instruction.
    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        alu_ctrl_t   alu_ctrl;
        logic [4:0]  rd;
        logic        reg_we;
        logic        illegal;
        logic [31:0] pc;
    } dec_bundle_t;

    // Number of entries held in the ID/EX buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32I decoder: instruction + PC + register read data in,
// ALU operands / operation / writeback info out.
// Optional feature: ID_ILLEGAL_DETECT_EN flags unrecognised encodings;
// without it they still decode as a harmless NOP (ADD, no writeback).
module alu_ctrl_dec
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output dec_bundle_t dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        legal;
    logic        we;
    alu_ctrl_t   ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        unused_rs1_field;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];
    assign imm_i  = sext12(instr[31:20]);
    assign imm_s  = sext12({instr[31:25], instr[11:7]});
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};
    // The rs1 index is consumed by the register file, not here.
    assign unused_rs1_field = ^instr[19:15];

    // Opcode/funct decode; any unrecognised encoding collapses to a NOP.
    always_comb begin
        legal = 1'b1;
        we    = 1'b0;
        ctrl  = ALU_ADD;
        src1  = rs1_data;
        src2  = 32'b0;
        case (opcode)
            OPC_OP: begin
                we   = 1'b1;
                src2 = rs2_data;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  ctrl = ALU_ADD;
                        3'b001:  ctrl = ALU_SLL;
                        3'b010:  ctrl = ALU_SLT;
                        3'b011:  ctrl = ALU_SLTU;
                        3'b100:  ctrl = ALU_XOR;
                        3'b101:  ctrl = ALU_SRL;
                        3'b110:  ctrl = ALU_OR;
                        default: ctrl = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    ctrl = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    ctrl = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                we   = 1'b1;
                src2 = imm_i;
                case (funct3)
                    3'b000: ctrl = ALU_ADD;
                    3'b010: ctrl = ALU_SLT;
                    3'b011: ctrl = ALU_SLTU;
                    3'b100: ctrl = ALU_XOR;
                    3'b110: ctrl = ALU_OR;
                    3'b111: ctrl = ALU_AND;
                    3'b001: begin
                        src2 = shamt;
                        if (funct7 == F7_BASE) ctrl = ALU_SLLI;
                        else                   legal = 1'b0;
                    end
                    default: begin
                        src2 = shamt;
                        if (funct7 == F7_BASE)     ctrl = ALU_SRLI;
                        else if (funct7 == F7_ALT) ctrl = ALU_SRAI;
                        else                       legal = 1'b0;
                    end
                endcase
            end
            OPC_LUI: begin
                we   = 1'b1;
                ctrl = ALU_PASS;
                src1 = 32'b0;
                src2 = imm_u;
            end
            OPC_AUIPC: begin
                we   = 1'b1;
                src1 = pc;
                src2 = imm_u;
            end
            OPC_LOAD: begin
                we   = 1'b1;
                src2 = imm_i;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) legal = 1'b0;
            end
            OPC_STORE: begin
                src2 = imm_s;
                if (funct3 > 3'b010) legal = 1'b0;
            end
            OPC_JAL: begin
                we   = 1'b1;
                src1 = pc;
                src2 = 32'd4;
            end
            OPC_JALR: begin
                we   = 1'b1;
                src1 = pc;
                src2 = 32'd4;
                if (funct3 != 3'b000) legal = 1'b0;
            end
            OPC_BRANCH: begin
                ctrl = ALU_SUB;
                src2 = rs2_data;
                if (funct3 == 3'b010 || funct3 == 3'b011) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            ctrl = ALU_ADD;
            src1 = rs1_data;
            src2 = 32'b0;
            we   = 1'b0;
        end
    end

    // Pack the bundle; writes to x0 never reach the register file.
    always_comb begin
        dec          = '0;
        dec.src1     = src1;
        dec.src2     = src2;
        dec.alu_ctrl = ctrl;
        dec.rd       = rd;
        dec.reg_we   = we && (rd != 5'd0);
        dec.pc       = pc;
`ifdef ID_ILLEGAL_DETECT_EN
        dec.illegal  = !legal;
`else
        dec.illegal  = 1'b0;
`endif
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decodes the incoming instruction and holds the
// result in a two-entry (main + skid) buffer between valid/ready handshakes.
// Handshake: a beat moves on a port in every cycle where its valid and ready
// are both high at the rising edge; valid never depends on ready, in_ready is
// a register, and a held output does not change until it is taken.
// Optional feature: ID_ILLEGAL_DETECT_EN adds the out_illegal port.
module id_ex_stage
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_src1,
    output logic [31:0] out_src2,
    output logic [3:0]  out_alu_ctrl,
    output logic [4:0]  out_rd,
    output logic        out_reg_we,
    output logic [31:0] out_pc,
`ifdef ID_ILLEGAL_DETECT_EN
    output logic        out_illegal,
`endif
    output logic [1:0]  dbg_state
);

    buf_state_t  state;
    buf_state_t  next_state;
    dec_bundle_t dec;
    dec_bundle_t main_q;
    dec_bundle_t skid_q;
    logic        accept;
    logic        drain;
    logic        load_main_new;
    logic        load_skid_new;
    logic        move_skid;

    alu_ctrl_dec u_dec (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .dec      (dec)
    );

    assign out_valid = (state != BUF_EMPTY);
    assign accept    = in_valid && in_ready && !flush;
    assign drain     = out_valid && out_ready;
    assign dbg_state = state;

    // Buffer occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BUF_EMPTY;
        else        state <= next_state;
    end

    // Occupancy transitions and the data moves each one implies; flush wins.
    always_comb begin
        next_state    = state;
        load_main_new = 1'b0;
        load_skid_new = 1'b0;
        move_skid     = 1'b0;
        if (flush) begin
            next_state = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        next_state    = BUF_ONE;
                        load_main_new = 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (accept && drain) begin
                        load_main_new = 1'b1;
                    end else if (accept) begin
                        next_state    = BUF_FULL;
                        load_skid_new = 1'b1;
                    end else if (drain) begin
                        next_state = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (drain) begin
                        next_state = BUF_ONE;
                        move_skid  = 1'b1;
                    end
                end
                default: next_state = BUF_EMPTY;
            endcase
        end
    end

    // in_ready is registered from the next occupancy; low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_ready <= 1'b0;
        else        in_ready <= (next_state != BUF_FULL);
    end

    // Main (head) and skid entries; the skid only ever refills the main slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_new)  main_q <= dec;
            else if (move_skid) main_q <= skid_q;
            if (load_skid_new)  skid_q <= dec;
        end
    end

    assign out_src1     = main_q.src1;
    assign out_src2     = main_q.src2;
    assign out_alu_ctrl = main_q.alu_ctrl;
    assign out_rd       = main_q.rd;
    assign out_reg_we   = main_q.reg_we;
    assign out_pc       = main_q.pc;

`ifdef ID_ILLEGAL_DETECT_EN
    assign out_illegal = main_q.illegal;
`else
    logic unused_illegal;
    assign unused_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: decode table, stall/flush/reset sequences and a
// randomized phase, all checked against a decode model and an ordered
// queue of expected output beats.
module tb_id_ex_stage;

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] pc;
    } exp_t;
    localparam int EW = $bits(exp_t);

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  ctrl;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  rd;
        logic        we;
    } vec_t;

    // funct3 -> ALU code for register-register ops with funct7 = 0
    localparam logic [3:0] OP_CTRL [8] = '{4'h0, 4'h2, 4'h8, 4'hC, 4'h5, 4'h3, 4'h6, 4'h7};
    localparam logic [6:0] OPC_LIST [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h63};

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, out_reg_we;
    logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
    logic [31:0] out_src1, out_src2, out_pc;
    logic [3:0]  out_alu_ctrl;
    logic [4:0]  out_rd;
    logic [1:0]  dbg_state;
`ifdef ID_ILLEGAL_DETECT_EN
    logic        out_illegal;
`endif

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_src1     (out_src1),
        .out_src2     (out_src2),
        .out_alu_ctrl (out_alu_ctrl),
        .out_rd       (out_rd),
        .out_reg_we   (out_reg_we),
        .out_pc       (out_pc),
`ifdef ID_ILLEGAL_DETECT_EN
        .out_illegal  (out_illegal),
`endif
        .dbg_state    (dbg_state)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int drain_cnt = 0;
    bit seen_edge = 1'b0;
    logic [EW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] ref_out(input logic [31:0] ins, input logic [31:0] pc,
                                               input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        int imm_i, imm_s;
        bit ok;
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = $signed(ins[31:20]);
        imm_s = $signed({ins[31:25], ins[11:7]});
        ok    = 1;
        e.src1 = a; e.src2 = 0; e.ctrl = 4'h0; e.rd = ins[11:7]; e.we = 1; e.pc = pc;
        case (ins[6:0])
            7'h33: begin
                e.src2 = b;
                if (f7 == 7'h00) e.ctrl = OP_CTRL[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) e.ctrl = 4'h1;
                else if (f7 == 7'h20 && f3 == 3'd5) e.ctrl = 4'h4;
                else ok = 0;
            end
            7'h13: begin
                e.src2 = imm_i;
                if (f3 == 3'd1) begin
                    e.src2 = ins[24:20];
                    if (f7 == 7'h00) e.ctrl = 4'h9; else ok = 0;
                end else if (f3 == 3'd5) begin
                    e.src2 = ins[24:20];
                    if (f7 == 7'h00) e.ctrl = 4'hA;
                    else if (f7 == 7'h20) e.ctrl = 4'hB;
                    else ok = 0;
                end else begin
                    e.ctrl = OP_CTRL[f3];
                end
            end
            7'h37: begin e.ctrl = 4'hF; e.src1 = 0; e.src2 = ins & 32'hFFFFF000; end
            7'h17: begin e.src1 = pc; e.src2 = ins & 32'hFFFFF000; end
            7'h03: begin e.src2 = imm_i; ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
            7'h23: begin e.src2 = imm_s; e.we = 0; ok = (f3 <= 3'd2); end
            7'h6F: begin e.src1 = pc; e.src2 = 4; end
            7'h67: begin e.src1 = pc; e.src2 = 4; ok = (f3 == 3'd0); end
            7'h63: begin e.ctrl = 4'h1; e.src2 = b; e.we = 0; ok = !(f3 inside {3'd2, 3'd3}); end
            default: ok = 0;
        endcase
        if (!ok) begin e.ctrl = 4'h0; e.src1 = a; e.src2 = 0; e.we = 0; end
        if (e.rd == 5'd0) e.we = 0;
        return e;
    endfunction

    // ---------------- scoreboard bookkeeping at the active edge ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            seen_edge = 1'b0;
        end else begin
            seen_edge = 1'b1;
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                drain_cnt++;
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready)
                exp_q.push_back(ref_out(in_instr, in_pc, rs1_data, rs2_data));
        end
    end

    // Compare the visible output beat and in_ready against the expected queue.
    task automatic sb_check();
        exp_t e;
        if (!rst_n) return;
        chk("in_ready", {31'b0, in_ready}, {31'b0, seen_edge && (exp_q.size() < 2)});
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("out_valid", {31'b0, out_valid}, 32'd1);
            chk("out_src1", out_src1, e.src1);
            chk("out_src2", out_src2, e.src2);
            chk("out_alu_ctrl", {28'b0, out_alu_ctrl}, {28'b0, e.ctrl});
            chk("out_rd", {27'b0, out_rd}, {27'b0, e.rd});
            chk("out_reg_we", {31'b0, out_reg_we}, {31'b0, e.we});
            chk("out_pc", out_pc, e.pc);
        end else begin
            chk("out_valid_idle", {31'b0, out_valid}, 32'd0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        sb_check();
    endtask

    task automatic drive_in(input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; in_instr = ins; in_pc = pc; rs1_data = a; rs2_data = b;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        chk({tag, "_alu_ctrl"}, {28'b0, out_alu_ctrl}, 32'd0);
        chk({tag, "_reg_we"}, {31'b0, out_reg_we}, 32'd0);
        chk({tag, "_src1"}, out_src1, 32'd0);
        chk({tag, "_src2"}, out_src2, 32'd0);
        chk({tag, "_rd"}, {27'b0, out_rd}, 32'd0);
        chk({tag, "_pc"}, out_pc, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int k;
        ins = $urandom();
        k   = $urandom_range(0, 9);
        if (k < 9) begin
            ins[6:0] = OPC_LIST[k];
            if ((k == 0 || k == 1) && $urandom_range(0, 3) != 0)
                ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        return ins;
    endfunction

    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        accepted;
        int          d0;

        vecs[0]  = '{32'hFFF10093, 32'h100, 32'd5, 32'd7, 4'h0, 32'd5, 32'hFFFFFFFF, 5'd1, 1'b1};
        vecs[1]  = '{32'h40325193, 32'h104, 32'd5, 32'd7, 4'hB, 32'd5, 32'h00000003, 5'd3, 1'b1};
        vecs[2]  = '{32'h123452B7, 32'h108, 32'd5, 32'd7, 4'hF, 32'd0, 32'h12345000, 5'd5, 1'b1};
        vecs[3]  = '{32'h00838333, 32'h10C, 32'd5, 32'd7, 4'h0, 32'd5, 32'd7,        5'd6, 1'b1};
        vecs[4]  = '{32'h40838333, 32'h110, 32'd5, 32'd7, 4'h1, 32'd5, 32'd7,        5'd6, 1'b1};
        vecs[5]  = '{32'hABCDE517, 32'h100, 32'd5, 32'd7, 4'h0, 32'h100, 32'hABCDE000, 5'd10, 1'b1};
        vecs[6]  = '{32'hFE812E23, 32'h114, 32'd5, 32'd7, 4'h0, 32'd5, 32'hFFFFFFFC, 5'd28, 1'b0};
        vecs[7]  = '{32'h008000EF, 32'h200, 32'd5, 32'd7, 4'h0, 32'h200, 32'd4,       5'd1, 1'b1};
        vecs[8]  = '{32'h00208463, 32'h118, 32'd5, 32'd7, 4'h1, 32'd5, 32'd7,        5'd8, 1'b0};
        vecs[9]  = '{32'h00000013, 32'h11C, 32'd5, 32'd7, 4'h0, 32'd5, 32'd0,        5'd0, 1'b0};
        vecs[10] = '{32'hFFFFFFFF, 32'h120, 32'd5, 32'd7, 4'h0, 32'd5, 32'd0,        5'd31, 1'b0};
        vecs[11] = '{32'h0051B113, 32'h124, 32'd5, 32'd7, 4'hC, 32'd5, 32'd5,        5'd2, 1'b1};
        vecs[12] = '{32'h0100A203, 32'h128, 32'd5, 32'd7, 4'h0, 32'd5, 32'd16,       5'd4, 1'b1};

        // power-on reset
        rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // decode table: one instruction at a time, outputs one cycle later
        for (int i = 0; i < 13; i++) begin
            tick();
            drive_in(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            tick();
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_ctrl", i), {28'b0, out_alu_ctrl}, {28'b0, vecs[i].ctrl});
            chk($sformatf("vec%0d_src1", i), out_src1, vecs[i].src1);
            chk($sformatf("vec%0d_src2", i), out_src2, vecs[i].src2);
            chk($sformatf("vec%0d_rd", i), {27'b0, out_rd}, {27'b0, vecs[i].rd});
            chk($sformatf("vec%0d_we", i), {31'b0, out_reg_we}, {31'b0, vecs[i].we});
            in_valid = 1'b0;
        end
        tick();

        // stall: three back-to-back inputs while the consumer is blocked
        d0 = drain_cnt;
        out_ready = 1'b0;
        drive_in(vecs[0].instr, 32'h300, 32'd1, 32'd2);
        tick();
        drive_in(vecs[3].instr, 32'h304, 32'd3, 32'd4);
        tick();
        chk("stall_in_ready_after_2nd", {31'b0, in_ready}, 32'd0);
        drive_in(vecs[2].instr, 32'h308, 32'd5, 32'd6);
        tick();
        chk("stall_3rd_held", {31'b0, in_ready}, 32'd0);
        chk("stall_valid_held", {31'b0, out_valid}, 32'd1);
        chk("stall_head_pc", out_pc, 32'h300);
        out_ready = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 8 && !accepted; i++) begin
            accepted = in_ready;
            tick();
        end
        chk("stall_3rd_accepted", {31'b0, accepted}, 32'd1);
        in_valid = 1'b0;
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) tick();
        chk("stall_drain_count", drain_cnt - d0, 32'd3);

        // flush while full with a new input offered in the same cycle
        out_ready = 1'b0;
        drive_in(vecs[4].instr, 32'h400, 32'd9, 32'd8);
        tick();
        drive_in(vecs[5].instr, 32'h404, 32'd9, 32'd8);
        tick();
        chk("flush_pre_full", {31'b0, in_ready}, 32'd0);
        flush = 1'b1;
        drive_in(vecs[7].instr, 32'h408, 32'd9, 32'd8);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        d0 = drain_cnt;
        tick();
        tick();
        chk("flush_nothing_emitted", drain_cnt - d0, 32'd0);

        // asynchronous reset while full
        out_ready = 1'b0;
        drive_in(vecs[1].instr, 32'h500, 32'd1, 32'd1);
        tick();
        drive_in(vecs[2].instr, 32'h504, 32'd1, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("rst_pre_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        d0 = drain_cnt;
        tick();
        tick();
        chk("rst_no_stale", drain_cnt - d0, 32'd0);

        // randomized traffic with occasional flushes and back-pressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_instr  = rand_instr();
            in_pc     = $urandom() & 32'hFFFFFFFC;
            rs1_data  = $urandom();
            rs2_data  = $urandom();
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 29) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) tick();
        chk("final_queue_empty", exp_q.size(), 32'd0);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL: in_valid  in  1  / in_ready  out  1  upstream handshake; transfer when both high.
REQ-004 SHALL: in_instr  in  32  / in_pc  in  32  / rs1_data  in  32  / rs2_data  in  32  fetched instruction, its PC, register-file read data.
REQ-005 SHALL: flush  in  1  discards all held entries.
REQ-006 SHALL: out_valid  out  1  / out_ready  in  1  downstream (ALU) handshake.
REQ-007 SHALL: out_src1  out  32, out_src2  out  32, out_alu_ctrl  out  4, out_rd  out  5, out_reg_we  out  1, out_pc  out  32  ALU operands, op, writeback info.
REQ-008 SHALL: out_illegal  out  1  unrecognised instruction flag (present only with ID_ILLEGAL_DETECT_EN).

Function
REQ-009 SHALL: alu_ctrl codes ADD 0000, SUB 0001, SLL 0010, SRL 0011, SRA 0100, XOR 0101, OR 0110, AND 0111, SLT 1000, SLLI 1001, SRLI 1010, SRAI 1011, SLTU 1100, PASS 1111.
REQ-010 SHALL: OP (0110011) -> funct3/funct7[5] select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; src1=rs1_data, src2=rs2_data; reg_we=1.
REQ-011 SHALL: OP-IMM (0010011) -> ADDI/SLTI/SLTIU/XORI/ORI/ANDI map to ADD/SLT/SLTU/XOR/OR/AND with src2=sign-extended instr[31:20]; SLLI/SRLI/SRAI map to 1001/1010/1011 with src2=zero-extended instr[24:20]; reg_we=1.
REQ-012 SHALL: LUI -> PASS, src2={instr[31:12],12'b0}; AUIPC -> ADD, src1=in_pc, src2 same U-immediate; reg_we=1.
REQ-013 SHALL: LOAD -> ADD, src2=I-imm, reg_we=1; STORE -> ADD, src2=S-imm {instr[31:25],instr[11:7]} sign-extended, reg_we=0.
REQ-014 SHALL: JAL/JALR -> ADD, src1=in_pc, src2=4, reg_we=1; BRANCH -> SUB, src1=rs1_data, src2=rs2_data, reg_we=0.
REQ-015 SHALL: out_reg_we forced 0 when rd=0; out_rd=instr[11:7]; out_pc=in_pc.
REQ-016 SHALL: latency exactly one cycle from accepted input to out_valid.
REQ-017 SHALL: two-entry buffer (main + skid); states EMPTY, ONE, FULL; in_ready = (state != FULL), registered.
REQ-018 SHALL: EMPTY+accept -> ONE; ONE+accept+no drain -> FULL; ONE+drain+no accept -> EMPTY; FULL+drain -> ONE (skid moves to main); simultaneous accept and drain in ONE stays ONE.
REQ-019 SHALL: outputs stable while out_valid=1 and out_ready=0; order strictly FIFO.
REQ-020 SHALL: flush dominates: next state EMPTY, in-flight input dropped, same-cycle in_valid ignored.

Reset
REQ-021 SHALL: on rst_n low all outputs 0 (out_valid=0, out_alu_ctrl=0000, out_reg_we=0, out_illegal=0), in_ready=0 during reset, 1 from first cycle after release; state EMPTY.
REQ-022 SHALL: reset mid-transfer discards both entries; no partial output.

Configuration
REQ-023 SHALL: with ID_ILLEGAL_DETECT_EN defined, unrecognised opcode or funct combination sets out_illegal=1, reg_we=0, alu_ctrl=ADD.
REQ-024 SHALL: without ID_ILLEGAL_DETECT_EN, out_illegal port absent; unrecognised instructions become NOP (ADD, reg_we=0).

Structure
REQ-025 SHALL: alu_ctrl codes, opcode constants and decoded-bundle struct live in shared package rv32i_pkg, also used by the ALU.
REQ-026 SHALL: combinational decode in sub-module alu_ctrl_dec; id_ex_stage holds buffer and handshake only.

Verification
REQ-027 SHALL: 0xFFF10093 (ADDI x1,x2,-1), rs1_data=5 -> next cycle ctrl 0000, src1 5, src2 0xFFFFFFFF, rd 1, reg_we 1.
REQ-028 SHALL: 0x40325193 (SRAI x3,x4,3) -> ctrl 1011, src2 0x00000003, rd 3.
REQ-029 SHALL: 0x123452B7 (LUI x5,0x12345) -> ctrl 1111, src2 0x12345000, rd 5.
REQ-030 SHALL: out_ready=0 for 3 cycles, 3 back-to-back inputs -> in_ready low after 2nd accepted, 3rd held upstream, outputs emerge in order once out_ready=1.
REQ-031 SHALL: flush in FULL with in_valid=1 -> out_valid 0 next cycle, in_ready 1, nothing emitted.
REQ-032 SHALL: rst_n pulsed low in FULL -> out_valid 0 immediately, no stale entry after release.
